ksw_seq_feeder: RTL and testbench
=================================

# ksw_seq_feeder

Sequencer that feeds the `loop_fission` score stage. It holds one query buffer and one target buffer, loaded one byte per cycle by the host. On `start` it walks every target row `r` and, within each row, every 16-lane query column block `t`. Each beat it emits the target byte plus a 128-bit, 16-lane query slice under a valid/ready handshake. The downstream score stage compares the two and applies `sc_mch`/`sc_mis`/`sc_N` per lane.

## Interface
- `QMAX`, 1024: query buffer depth in bytes.
- `TMAX`, 1024: target buffer depth in bytes.
- `LANES`, 16: bytes per query slice; fixed at 16 so the slice is 128 bits.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  byte write strobe; ignored while `busy`.
- `wr_sel`  in  1  0 = query buffer, 1 = target buffer.
- `wr_addr`  in  10  byte address.
- `wr_data`  in  8  base code (0–3 = ACGT, 4 = N).
- `qlen`  in  11  query length; sampled on accepted `start`.
- `tlen`  in  11  target length; sampled on accepted `start`.
- `start`  in  1  job start; honoured only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at job end.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_r`  out  10  target row index.
- `out_t`  out  10  query column base; always a multiple of 16.
- `out_tbyte`  out  8  `target[out_r]`.
- `out_qslice`  out  128  lane i at bits [8i+7:8i] = `query[out_t+i]`.
- `out_row_last`  out  1  last column block of the current row.
- `out_last`  out  1  final beat of the job.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - `wr_en` writes `wr_data` into the buffer selected by `wr_sel`.
  - `start` latches `qlen` and `tlen`, each saturated to `QMAX`/`TMAX`.
  - If either latched length is 0, go to FIN and emit no beats.
  - Otherwise set r=0, t=0 and go to RUN.
- RUN:
  - Beat fires when `out_valid && out_ready`.
  - On a fire with t+16 < qlen: t += 16.
  - Otherwise t = 0 and r += 1.
  - Firing the beat with r = tlen−1 and `out_row_last` high goes to FIN.
- FIN: `done`=1 for one cycle, `busy` drops in the same cycle, then IDLE.
- Beats per job = tlen × ceil(qlen/16), issued in row-major order.
- Tail lanes (index ≥ qlen − t in the last block) take the pad value defined under Configuration.
- `out_row_last` = (t+16 ≥ qlen).
- `out_last` = `out_row_last` && (r = tlen−1).
- `start` while `busy`: ignored.
- `wr_en` while `busy`: dropped; buffer contents are unchanged.

## Timing
- Reset values:
  - state IDLE; `busy`, `done`, `out_valid`, `out_row_last`, `out_last` = 0.
  - `out_r`, `out_t`, `out_tbyte`, `out_qslice` = 0.
  - Buffer contents are not cleared.
- Write latency: a byte written in cycle N is readable from cycle N+1.
- Start latency: `start` in cycle N gives `out_valid`=1 with beat (r=0, t=0) in cycle N+1.
- Throughput: one beat per cycle while `out_ready` is held high.
- All outputs are registered.
- Payload holds stable while `out_valid && !out_ready`; `out_valid` never drops without a fire.
- The next beat appears in the cycle after a fire with no bubble.
- After the last fire, `out_valid`=0 and `done`=1 in the next cycle.
- Zero-length job: `done` is asserted 2 cycles after `start` (N+1 FIN, N+2 pulse register).
- Reset mid-job:
  - immediate abort, no `done`, outputs go to reset values asynchronously.
  - Buffers keep their contents, so a re-`start` reproduces the job.

## Configuration
- `KSW_FEED_PAD_N_EN` defined: tail lanes are padded with 8'h04 (N), so the score stage applies `sc_N` to them.
- Not defined: tail lanes are padded with 8'hFF, which the score stage treats as don't-care.
- No other behaviour changes.

## Structure
- Package `ksw_pkg`:
  - `LANES`, `BYTE_W`=8, `SLICE_W`=128.
  - base codes `BASE_N`=8'h04 and `PAD_X`=8'hFF.
  - state typedef `feed_state_t` {IDLE, RUN, FIN}.
- Sub-module `ksw_seq_buf`:
  - query byte array with a 16-byte-wide read port at address t, including tail masking by qlen.
  - target byte array with a single-byte read port.
- Top module: FSM, r/t counters, output register stage with hold-on-stall.

## Test plan
- Load query ACGT×5 (qlen=20) and target bytes 0,1,2 (tlen=3); start with `out_ready`=1 → 6 beats:
  - (r,t) = (0,0)(0,16)(1,0)(1,16)(2,0)(2,16).
  - In the t=16 beats, lanes 4–15 carry the pad value.
  - `out_last` on beat 6; `done` one cycle later.
- Same job with `out_ready` toggling 1,0,0,1… → payload stable during stalls; same 6 beats in the same order; no duplicates or drops.
- qlen=16, tlen=1 → exactly one beat, with `out_row_last`=`out_last`=1 and no padded lanes.
- qlen=0, tlen=5 → no `out_valid`; `done` two cycles after `start`.
- Assert `start` and `wr_en` (address 0, data 3) mid-job → job unaffected; query[0] unchanged after `done`.
- Drop `rst_n` during beat (1,0), then release and re-start → all outputs 0 immediately; no `done` for the aborted job; the re-run matches the first run beat-for-beat.

Source files
------------

// File: rtl/ksw_pkg.sv
// Shared types and constants for the ksw sequence feeder.
// Tail padding value is selected in ksw_seq_buf by KSW_FEED_PAD_N_EN.
package ksw_pkg;
   localparam int QMAX    = 1024;
   localparam int TMAX    = 1024;
   localparam int LANES   = 16;
   localparam int BYTE_W  = 8;
   localparam int SLICE_W = 128;

   localparam logic [7:0] BASE_N = 8'h04;
   localparam logic [7:0] PAD_X  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } feed_state_t;

   // Clamp a requested length to the buffer depth.
   function automatic logic [10:0] sat_len(input logic [10:0] len, input logic [10:0] max);
      return (len > max) ? max : len;
   endfunction
endpackage

// File: rtl/ksw_seq_buf.sv
// Query/target byte buffers with a 16-lane query read port and tail padding.
// KSW_FEED_PAD_N_EN: pad tail lanes with N (8'h04) instead of don't-care (8'hFF).
module ksw_seq_buf
   import ksw_pkg::*;
(
   input  logic               clk,
   input  logic               wr_en_i,
   input  logic               wr_sel_i,
   input  logic [9:0]         wr_addr_i,
   input  logic [7:0]         wr_data_i,
   input  logic [9:0]         rd_t_i,
   input  logic [9:0]         rd_r_i,
   input  logic [10:0]        qlen_i,
   output logic [SLICE_W-1:0] qslice_o,
   output logic [7:0]         tbyte_o
);
`ifdef KSW_FEED_PAD_N_EN
   localparam logic [7:0] PAD_V = BASE_N;
`else
   localparam logic [7:0] PAD_V = PAD_X;
`endif

   logic [7:0] qmem_q [QMAX];
   logic [7:0] tmem_q [TMAX];

   // Byte writes from the host; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         if (wr_sel_i) begin
            tmem_q[wr_addr_i] <= wr_data_i;
         end else begin
            qmem_q[wr_addr_i] <= wr_data_i;
         end
      end
   end

   // Combinational read; lanes at or beyond qlen carry the pad byte.
   always_comb begin
      qslice_o = '0;
      for (int i = 0; i < LANES; i++) begin
         if (({1'b0, rd_t_i} + 11'(i)) < qlen_i) begin
            qslice_o[i*8 +: 8] = qmem_q[rd_t_i + 10'(i)];
         end else begin
            qslice_o[i*8 +: 8] = PAD_V;
         end
      end
      tbyte_o = tmem_q[rd_r_i];
   end
endmodule

// File: rtl/ksw_seq_feeder.sv
// Row-major sequencer feeding target bytes and 16-lane query slices downstream.
// Optional macro KSW_FEED_PAD_N_EN selects N padding for tail lanes (see ksw_seq_buf).
module ksw_seq_feeder
   import ksw_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic               wr_sel,
   input  logic [9:0]         wr_addr,
   input  logic [7:0]         wr_data,
   input  logic [10:0]        qlen,
   input  logic [10:0]        tlen,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [9:0]         out_r,
   output logic [9:0]         out_t,
   output logic [7:0]         out_tbyte,
   output logic [SLICE_W-1:0] out_qslice,
   output logic               out_row_last,
   output logic               out_last
);
   feed_state_t        state_q, state_d;
   logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic [9:0]         r_q, r_d, t_q, t_d;
   logic [7:0]         tbyte_q, tbyte_d;
   logic [SLICE_W-1:0] qslice_q, qslice_d;
   logic               row_last_q, row_last_d, last_q, last_d;
   logic [10:0]        qlen_q, qlen_d, tlen_q, tlen_d;

   logic [10:0]        qlen_sat_s, tlen_sat_s, qlen_rd_s, tlen_rd_s;
   logic [9:0]         rd_t_s, rd_r_s;
   logic [SLICE_W-1:0] rd_qslice_s;
   logic [7:0]         rd_tbyte_s;
   logic               nxt_row_last_s, nxt_last_s, fire_s;

   assign qlen_sat_s = sat_len(qlen, 11'(QMAX));
   assign tlen_sat_s = sat_len(tlen, 11'(TMAX));
   assign fire_s     = valid_q && out_ready;

   ksw_seq_buf u_buf (
      .clk       (clk),
      .wr_en_i   (wr_en && !busy_q),
      .wr_sel_i  (wr_sel),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_t_i    (rd_t_s),
      .rd_r_i    (rd_r_s),
      .qlen_i    (qlen_rd_s),
      .qslice_o  (rd_qslice_s),
      .tbyte_o   (rd_tbyte_s)
   );

   // Address of the beat that would be loaded next: (0,0) from IDLE, else the successor.
   always_comb begin
      rd_t_s    = 10'd0;
      rd_r_s    = 10'd0;
      qlen_rd_s = qlen_q;
      tlen_rd_s = tlen_q;
      if (state_q == IDLE) begin
         qlen_rd_s = qlen_sat_s;
         tlen_rd_s = tlen_sat_s;
      end else if (!row_last_q) begin
         rd_t_s = t_q + 10'd16;
         rd_r_s = r_q;
      end else begin
         rd_t_s = 10'd0;
         rd_r_s = r_q + 10'd1;
      end
      nxt_row_last_s = (({1'b0, rd_t_s} + 11'd16) >= qlen_rd_s);
      nxt_last_s     = nxt_row_last_s && ({1'b0, rd_r_s} == (tlen_rd_s - 11'd1));
   end

   // Next-state and output-register logic.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      valid_d    = valid_q;
      r_d        = r_q;
      t_d        = t_q;
      tbyte_d    = tbyte_q;
      qslice_d   = qslice_q;
      row_last_d = row_last_q;
      last_d     = last_q;
      qlen_d     = qlen_q;
      tlen_d     = tlen_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               qlen_d = qlen_sat_s;
               tlen_d = tlen_sat_s;
               busy_d = 1'b1;
               if ((qlen_sat_s == 11'd0) || (tlen_sat_s == 11'd0)) begin
                  state_d = FIN;
               end else begin
                  state_d    = RUN;
                  valid_d    = 1'b1;
                  r_d        = rd_r_s;
                  t_d        = rd_t_s;
                  tbyte_d    = rd_tbyte_s;
                  qslice_d   = rd_qslice_s;
                  row_last_d = nxt_row_last_s;
                  last_d     = nxt_last_s;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (fire_s && last_q) begin
               state_d = FIN;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (fire_s) begin
               r_d        = rd_r_s;
               t_d        = rd_t_s;
               tbyte_d    = rd_tbyte_s;
               qslice_d   = rd_qslice_s;
               row_last_d = nxt_row_last_s;
               last_d     = nxt_last_s;
            end else begin
               state_d = RUN;
            end
         end
         FIN: begin
            // done already pulsed on the last fire; zero-length jobs pulse here
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = !done_q;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         r_q        <= 10'd0;
         t_q        <= 10'd0;
         tbyte_q    <= 8'd0;
         qslice_q   <= '0;
         row_last_q <= 1'b0;
         last_q     <= 1'b0;
         qlen_q     <= 11'd0;
         tlen_q     <= 11'd0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         r_q        <= r_d;
         t_q        <= t_d;
         tbyte_q    <= tbyte_d;
         qslice_q   <= qslice_d;
         row_last_q <= row_last_d;
         last_q     <= last_d;
         qlen_q     <= qlen_d;
         tlen_q     <= tlen_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign out_valid    = valid_q;
   assign out_r        = r_q;
   assign out_t        = t_q;
   assign out_tbyte    = tbyte_q;
   assign out_qslice   = qslice_q;
   assign out_row_last = row_last_q;
   assign out_last     = last_q;
endmodule

// File: tb/tb_ksw_seq_feeder.sv
// Scoreboard bench for ksw_seq_feeder: directed jobs, stalls, mid-job noise and reset abort.
module tb_ksw_seq_feeder;
   typedef struct packed {
      logic [9:0]   r;
      logic [9:0]   t;
      logic [7:0]   tb;
      logic [127:0] qs;
      logic         rl;
      logic         last;
   } beat_t;

`ifdef KSW_FEED_PAD_N_EN
   localparam logic [7:0] PADV = 8'h04;
`else
   localparam logic [7:0] PADV = 8'hFF;
`endif
   localparam logic [127:0] SL0  = {4{32'h03020100}};
   localparam logic [127:0] SL16 = {{12{PADV}}, 32'h03020100};

   logic         clk = 1'b0;
   logic         rst_n, wr_en, wr_sel, start, out_ready;
   logic [9:0]   wr_addr;
   logic [7:0]   wr_data;
   logic [10:0]  qlen, tlen;
   logic         busy, done, out_valid, out_row_last, out_last;
   logic [9:0]   out_r, out_t;
   logic [7:0]   out_tbyte;
   logic [127:0] out_qslice;

   beat_t exp_q[$];
   beat_t got_b;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_done   = 0;
   bit    pend_done = 1'b0;
   bit    zl_ok     = 1'b0;
   bit    stall_mode = 1'b0;

   ksw_seq_feeder dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .qlen(qlen), .tlen(tlen), .start(start), .busy(busy),
      .done(done), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
      .out_t(out_t), .out_tbyte(out_tbyte), .out_qslice(out_qslice),
      .out_row_last(out_row_last), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Monitor: checks each presented beat against the queue head, pops on fire.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pend_done) begin
            n_checks++;
            if (!(done === 1'b1 && out_valid === 1'b0)) begin
               n_fail++;
               $display("FAIL done_after_last: done=%0b out_valid=%0b required done=1 out_valid=0", done, out_valid);
            end
            pend_done = 1'b0;
         end else if (done) begin
            n_checks++;
            if (!zl_ok) begin
               n_fail++;
               $display("FAIL unexpected_done: done=1 required 0");
            end
         end
         if (done) n_done++;
         if (out_valid) begin
            got_b = '{out_r, out_t, out_tbyte, out_qslice, out_row_last, out_last};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: r=%0d t=%0d required no beat", out_r, out_t);
            end else begin
               if (got_b !== exp_q[0]) begin
                  n_fail++;
                  $display("FAIL beat: got r=%0d t=%0d tb=%0h qs=%h rl=%0b last=%0b required r=%0d t=%0d tb=%0h qs=%h rl=%0b last=%0b",
                           got_b.r, got_b.t, got_b.tb, got_b.qs, got_b.rl, got_b.last,
                           exp_q[0].r, exp_q[0].t, exp_q[0].tb, exp_q[0].qs, exp_q[0].rl, exp_q[0].last);
               end
               if (out_ready) begin
                  if (exp_q[0].last) pend_done = 1'b1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input logic [9:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic push_job20();
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back('{10'(r), 10'd0,  8'(r), SL0,  1'b0, 1'b0});
         exp_q.push_back('{10'(r), 10'd16, 8'(r), SL16, 1'b1, (r == 2)});
      end
   endtask

   task automatic start_job(input logic [10:0] q, input logic [10:0] t);
      qlen = q; tlen = t; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int base = n_done;
      int k = 0;
      while ((n_done == base) && (k < budget)) begin
         out_ready = stall_mode ? ((k % 3) == 2) : 1'b1;
         cyc();
         k++;
      end
      out_ready = 1'b1;
      n_checks++;
      if (n_done == base) begin
         n_fail++;
         $display("FAIL %s_timeout: done count=%0d required %0d", name, n_done, base + 1);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_beats_left: remaining=%0d required 0", name, exp_q.size());
      end
   endtask

   task automatic check_zero_outputs(input string name);
      n_checks++;
      if ({busy, done, out_valid, out_row_last, out_last, out_r, out_t, out_tbyte, out_qslice} !== '0) begin
         n_fail++;
         $display("FAIL %s: busy=%0b done=%0b valid=%0b r=%0d t=%0d tb=%0h qs=%h required all 0",
                  name, busy, done, out_valid, out_r, out_t, out_tbyte, out_qslice);
      end
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 10'd0; wr_data = 8'd0;
      qlen = 11'd0; tlen = 11'd0; start = 1'b0; out_ready = 1'b0;
      #2;
      check_zero_outputs("reset_state");
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 20; i++) wr(1'b0, 10'(i), 8'(i % 4));
      for (int i = 0; i < 3; i++) wr(1'b1, 10'(i), 8'(i));

      // Job 1: straight run
      out_ready = 1'b1;
      push_job20();
      start_job(11'd20, 11'd3);
      wait_done("job_plain", 100);

      // Job 2: ready pattern 1,0,0 repeating
      out_ready = 1'b1;
      push_job20();
      start_job(11'd20, 11'd3);
      stall_mode = 1'b1;
      wait_done("job_stall", 200);
      stall_mode = 1'b0;

      // Job 3: start and write while busy must be ignored
      push_job20();
      start_job(11'd20, 11'd3);
      qlen = 11'd16; tlen = 11'd1; start = 1'b1;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 10'd0; wr_data = 8'd3;
      cyc();
      start = 1'b0; wr_en = 1'b0;
      wait_done("job_noise", 100);

      // Job 4: single full block, also proves query[0] kept its value
      exp_q.push_back('{10'd0, 10'd0, 8'd0, SL0, 1'b1, 1'b1});
      start_job(11'd16, 11'd1);
      wait_done("job_single", 50);

      // Job 5: zero-length query
      zl_ok = 1'b1;
      start_job(11'd0, 11'd5);
      n_checks++;
      if (!(done === 1'b0 && busy === 1'b1)) begin
         n_fail++;
         $display("FAIL zero_len_n1: done=%0b busy=%0b required done=0 busy=1", done, busy);
      end
      cyc();
      n_checks++;
      if (!(done === 1'b1 && busy === 1'b0)) begin
         n_fail++;
         $display("FAIL zero_len_n2: done=%0b busy=%0b required done=1 busy=0", done, busy);
      end
      cyc();
      zl_ok = 1'b0;
      repeat (3) cyc();

      // Job 6: reset during beat (1,0), then rerun
      push_job20();
      start_job(11'd20, 11'd3);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid && out_r == 10'd1 && out_t == 10'd0) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reach_beat_1_0: not seen required seen");
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("abort_reset");
      exp_q.delete();
      pend_done = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      push_job20();
      start_job(11'd20, 11'd3);
      wait_done("job_rerun", 100);
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
